// File: rtl/slip_frame_rx.sv
// SLIP frame decoder: un-escapes received bytes, writes them to sequential
// buffer addresses starting at 0, and reports frame length/status at END.
//
// state   | meaning
// NORMAL  | plain data; END closes the frame, ESC starts an escape pair
// ESCAPE  | previous byte was ESC; expect ESC_END or ESC_ESC
// DISCARD | frame already failed; drop bytes until END reports the error
module slip_frame_rx #(
    parameter int ADDR_W      = 8,
    parameter int MAX_LEN     = 2**ADDR_W,
    parameter bit CHECKSUM_EN = 1'b0,
    parameter bit DROP_EMPTY  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_en,
    output logic [ADDR_W:0]   frame_len,
    output logic              frame_ok,
    output logic              frame_err,
    output logic [1:0]        err_code
);

    localparam logic [7:0]    END_B   = 8'hC0;
    localparam logic [7:0]    ESC_B   = 8'hDB;
    localparam logic [7:0]    ESC_END = 8'hDC;
    localparam logic [7:0]    ESC_ESC = 8'hDD;
    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_LEN);

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_ESC  = 2'd1;
    localparam logic [1:0] ERR_OVF  = 2'd2;
    localparam logic [1:0] ERR_SUM  = 2'd3;

    typedef enum logic [1:0] {NORMAL, ESCAPE, DISCARD} state_t;

    state_t            state, state_d;
    logic [ADDR_W:0]   count, count_d;
    logic [7:0]        sum, sum_d;
    logic [1:0]        err, err_d;

    logic [7:0]        wr_data_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic              wr_en_d;
    logic [ADDR_W:0]   frame_len_d;
    logic              frame_ok_d;
    logic              frame_err_d;
    logic [1:0]        err_code_d;

    logic              do_store;
    logic              do_close;
    logic [7:0]        store_byte;

    // State and registered outputs; pulses fall back to 0 via the comb defaults.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= NORMAL;
            count     <= '0;
            sum       <= '0;
            err       <= ERR_NONE;
            wr_data   <= '0;
            wr_addr   <= '0;
            wr_en     <= 1'b0;
            frame_len <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= '0;
        end else begin
            state     <= state_d;
            count     <= count_d;
            sum       <= sum_d;
            err       <= err_d;
            wr_data   <= wr_data_d;
            wr_addr   <= wr_addr_d;
            wr_en     <= wr_en_d;
            frame_len <= frame_len_d;
            frame_ok  <= frame_ok_d;
            frame_err <= frame_err_d;
            err_code  <= err_code_d;
        end
    end

    // Decode one byte: classify it, then apply store or frame-close actions.
    always_comb begin
        state_d     = state;
        count_d     = count;
        sum_d       = sum;
        err_d       = err;
        wr_data_d   = wr_data;
        wr_addr_d   = wr_addr;
        wr_en_d     = 1'b0;
        frame_len_d = frame_len;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code;
        do_store    = 1'b0;
        do_close    = 1'b0;
        store_byte  = rx_data;

        if (rx_valid) begin
            case (state)
                NORMAL: begin
                    if (rx_data == END_B)      do_close = 1'b1;
                    else if (rx_data == ESC_B) state_d  = ESCAPE;
                    else                       do_store = 1'b1;
                end
                ESCAPE: begin
                    state_d = NORMAL;
                    if (rx_data == ESC_END) begin
                        do_store   = 1'b1;
                        store_byte = END_B;
                    end else if (rx_data == ESC_ESC) begin
                        do_store   = 1'b1;
                        store_byte = ESC_B;
                    end else begin
                        if (err == ERR_NONE) err_d = ERR_ESC;
                        if (rx_data == END_B) do_close = 1'b1;
                        else                  state_d  = DISCARD;
                    end
                end
                default: begin
                    if (rx_data == END_B) do_close = 1'b1;
                end
            endcase
        end

        if (do_store) begin
            if (count == MAX_CNT) begin
                // Full buffer: refuse the byte so addresses never wrap.
                if (err_d == ERR_NONE) err_d = ERR_OVF;
                state_d = DISCARD;
            end else begin
                wr_data_d = store_byte;
                wr_addr_d = count[ADDR_W-1:0];
                wr_en_d   = 1'b1;
                count_d   = count + 1'b1;
                sum_d     = sum + store_byte;
            end
        end

        if (do_close) begin
            frame_len_d = count;
            if (err_d != ERR_NONE) begin
                frame_err_d = 1'b1;
                err_code_d  = err_d;
            end else if (CHECKSUM_EN && count != '0 && sum != 8'h00) begin
                frame_err_d = 1'b1;
                err_code_d  = ERR_SUM;
            end else if (!(DROP_EMPTY && count == '0)) begin
                frame_ok_d = 1'b1;
            end
            count_d = '0;
            sum_d   = '0;
            err_d   = ERR_NONE;
            state_d = NORMAL;
        end
    end

endmodule

// File: tb/tb_slip_frame_rx.sv
// Directed bench for slip_frame_rx: three instances (default, tiny buffer,
// checksum enabled); expected writes/frames queued as bytes are sent.
module tb_slip_frame_rx;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [7:0] rxd [3];
    logic       rxv [3];

    logic [7:0] wd0, wd1, wd2;
    logic [7:0] wa0;
    logic [1:0] wa1;
    logic [7:0] wa2;
    logic       we0, we1, we2;
    logic [8:0] fl0;
    logic [2:0] fl1;
    logic [8:0] fl2;
    logic       ok0, ok1, ok2, er0, er1, er2;
    logic [1:0] ec0, ec1, ec2;

    slip_frame_rx u_d0 (
        .clk(clk), .reset(reset), .rx_data(rxd[0]), .rx_valid(rxv[0]),
        .wr_data(wd0), .wr_addr(wa0), .wr_en(we0), .frame_len(fl0),
        .frame_ok(ok0), .frame_err(er0), .err_code(ec0));

    slip_frame_rx #(.ADDR_W(2), .MAX_LEN(4)) u_d1 (
        .clk(clk), .reset(reset), .rx_data(rxd[1]), .rx_valid(rxv[1]),
        .wr_data(wd1), .wr_addr(wa1), .wr_en(we1), .frame_len(fl1),
        .frame_ok(ok1), .frame_err(er1), .err_code(ec1));

    slip_frame_rx #(.CHECKSUM_EN(1'b1)) u_d2 (
        .clk(clk), .reset(reset), .rx_data(rxd[2]), .rx_valid(rxv[2]),
        .wr_data(wd2), .wr_addr(wa2), .wr_en(we2), .frame_len(fl2),
        .frame_ok(ok2), .frame_err(er2), .err_code(ec2));

    typedef struct {
        int         dut;
        int         addr;
        logic [7:0] data;
    } wexp_t;

    typedef struct {
        int         dut;
        logic       ok;
        logic [1:0] code;
        int         len;
    } fexp_t;

    wexp_t wq[$];
    fexp_t fq[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon(input int d, input logic we, input logic [7:0] wd, input int wa,
                       input logic ok, input logic er, input logic [1:0] ec, input int fl);
        wexp_t w;
        fexp_t f;
        if (we) begin
            chk($sformatf("write_expected_d%0d", d), int'(wq.size() > 0), 1);
            if (wq.size() > 0) begin
                w = wq.pop_front();
                chk("wr_dut", d, w.dut);
                chk($sformatf("wr_addr_d%0d", d), wa, w.addr);
                chk($sformatf("wr_data_d%0d", d), int'(wd), int'(w.data));
            end
        end
        if (ok || er) begin
            chk($sformatf("pulse_no_wr_d%0d", d), int'(we), 0);
            chk($sformatf("frame_expected_d%0d", d), int'(fq.size() > 0), 1);
            if (fq.size() > 0) begin
                f = fq.pop_front();
                chk("frame_dut", d, f.dut);
                chk($sformatf("frame_ok_d%0d", d), int'(ok), int'(f.ok));
                chk($sformatf("frame_err_d%0d", d), int'(er), int'(!f.ok));
                chk($sformatf("frame_len_d%0d", d), fl, f.len);
                if (!f.ok) chk($sformatf("err_code_d%0d", d), int'(ec), int'(f.code));
            end
        end
    endtask

    // Scoreboard side: compare every DUT strobe against the queued expectations.
    always @(negedge clk) begin
        if (!reset) begin
            mon(0, we0, wd0, int'(wa0), ok0, er0, ec0, int'(fl0));
            mon(1, we1, wd1, int'(wa1), ok1, er1, ec1, int'(fl1));
            mon(2, we2, wd2, int'(wa2), ok2, er2, ec2, int'(fl2));
        end
    end

    task automatic send(input int d, input logic [7:0] b);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) rxv[i] = 1'b0;
        rxd[d] = b;
        rxv[d] = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) rxv[i] = 1'b0;
        end
    endtask

    task automatic ew(input int d, input int a, input logic [7:0] b);
        wexp_t w;
        w.dut = d; w.addr = a; w.data = b;
        wq.push_back(w);
    endtask

    task automatic ef(input int d, input logic ok, input logic [1:0] code, input int len);
        fexp_t f;
        f.dut = d; f.ok = ok; f.code = code; f.len = len;
        fq.push_back(f);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_we0"}, int'(we0), 0);
        chk({tag, "_ok0"}, int'(ok0), 0);
        chk({tag, "_er0"}, int'(er0), 0);
        chk({tag, "_fl0"}, int'(fl0), 0);
        chk({tag, "_wa0"}, int'(wa0), 0);
        chk({tag, "_wd0"}, int'(wd0), 0);
        chk({tag, "_ec0"}, int'(ec0), 0);
        chk({tag, "_we1"}, int'(we1), 0);
        chk({tag, "_fl1"}, int'(fl1), 0);
        chk({tag, "_we2"}, int'(we2), 0);
        chk({tag, "_fl2"}, int'(fl2), 0);
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rxd[i] = 8'h00;
            rxv[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        reset_checks("reset");

        // Plain frame
        ew(0, 0, 8'h01); send(0, 8'h01);
        ew(0, 1, 8'h02); send(0, 8'h02);
        ew(0, 2, 8'h03); send(0, 8'h03);
        ef(0, 1'b1, 2'd0, 3); send(0, 8'hC0);
        idle(2);

        // Escapes, then a new frame restarts at address 0
        ew(0, 0, 8'h41); send(0, 8'h41);
        send(0, 8'hDB);
        ew(0, 1, 8'hC0); send(0, 8'hDC);
        send(0, 8'hDB);
        ew(0, 2, 8'hDB); send(0, 8'hDD);
        ew(0, 3, 8'h42); send(0, 8'h42);
        ef(0, 1'b1, 2'd0, 4); send(0, 8'hC0);
        ew(0, 0, 8'h77); send(0, 8'h77);
        ef(0, 1'b1, 2'd0, 1); send(0, 8'hC0);
        idle(1);

        // Bad escape, rest discarded
        ew(0, 0, 8'h41); send(0, 8'h41);
        send(0, 8'hDB);
        send(0, 8'h55);
        send(0, 8'h66);
        ef(0, 1'b0, 2'd1, 1); send(0, 8'hC0);
        // ESC directly followed by END
        ew(0, 0, 8'h41); send(0, 8'h41);
        send(0, 8'hDB);
        ef(0, 1'b0, 2'd1, 1); send(0, 8'hC0);
        // Empty frames are suppressed
        send(0, 8'hC0);
        send(0, 8'hC0);
        idle(3);

        // Overflow on a 4-byte buffer
        for (int i = 0; i < 6; i++) begin
            if (i < 4) ew(1, i, 8'(8'h11 + i));
            send(1, 8'(8'h11 + i));
        end
        ef(1, 1'b0, 2'd2, 4); send(1, 8'hC0);
        // Exactly full frame is legal
        for (int i = 0; i < 4; i++) begin
            ew(1, i, 8'(8'hA0 + i));
            send(1, 8'(8'hA0 + i));
        end
        ef(1, 1'b1, 2'd0, 4); send(1, 8'hC0);
        ew(1, 0, 8'h5A); send(1, 8'h5A);
        ef(1, 1'b1, 2'd0, 1); send(1, 8'hC0);
        idle(2);

        // Checksum
        ew(2, 0, 8'h10); send(2, 8'h10);
        ew(2, 1, 8'h20); send(2, 8'h20);
        ew(2, 2, 8'hD0); send(2, 8'hD0);
        ef(2, 1'b1, 2'd0, 3); send(2, 8'hC0);
        ew(2, 0, 8'h10); send(2, 8'h10);
        ew(2, 1, 8'h20); send(2, 8'h20);
        ew(2, 2, 8'hD1); send(2, 8'hD1);
        ef(2, 1'b0, 2'd3, 3); send(2, 8'hC0);
        idle(2);

        // Reset mid-frame drops the partial frame
        ew(0, 0, 8'h07); send(0, 8'h07);
        ew(0, 1, 8'h08); send(0, 8'h08);
        idle(2);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        @(negedge clk);
        reset_checks("midreset");
        ew(0, 0, 8'h05); send(0, 8'h05);
        ef(0, 1'b1, 2'd0, 1); send(0, 8'hC0);
        idle(4);

        chk("writes_left", wq.size(), 0);
        chk("frames_left", fq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
